fpa_result_fifo: RTL and testbench
==================================

# fpa_result_fifo

Registered output stage placed directly downstream of the combinational `fpa` adder. It captures each `{sign, exp, mantis}` result through a valid/ready handshake and buffers results in a small FIFO, so the adder's combinational path ends at a register. Each entry is tagged with an IEEE-754 single-precision class. Optional saturating counters track NaN and infinity results for debug.

## Interface
- `DEPTH`, 4: FIFO entries. Must be a power of two and ≥ 2.
- `CNT_W`, 16: width of each statistics counter.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  producer presents a result.
- `in_ready`  out  1  FIFO can accept a result. Equal to `count != DEPTH`.
- `sign`  in  1  result sign, from `fpa`.
- `exp`  in  8  result exponent, from `fpa`.
- `mantis`  in  23  result mantissa, from `fpa`.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  consumer accepts the head entry.
- `out_result`  out  32  head entry as `{sign, exp, mantis}`.
- `out_class`  out  3  class of the head entry: 0 normal, 1 zero, 2 denormal, 3 infinity, 4 NaN.
- `clear_stats`  in  1  synchronous clear of both counters.
- `nan_count`  out  CNT_W  number of accepted NaN results.
- `inf_count`  out  CNT_W  number of accepted ±infinity results.

## Operation
- **Push:** occurs on `in_valid && in_ready`. The entry written is `{sign, exp, mantis}` together with its class, computed combinationally at the input.
- **Pop:** occurs on `out_valid && out_ready`. The read pointer advances by one.
- **Classification**, applied in order, first match wins:
  - `exp == 8'hFF` and `mantis != 0` → NaN (4).
  - `exp == 8'hFF` → infinity (3).
  - `exp == 0` and `mantis == 0` → zero (1).
  - `exp == 0` → denormal (2).
  - Otherwise → normal (0).
  - Sign does not affect class.
- **Storage:** write pointer, read pointer and `count` (log2(DEPTH)+1 bits). Both pointers wrap modulo DEPTH with no special case at the wrap.
- **Simultaneous push and pop:** `count` is unchanged, both pointers advance, and both operations take effect.
- **Full:** `in_ready = 0`. Input data are ignored. The producer must hold its data, because `fpa` is combinational and holds its output as long as its operands are held.
- **Empty:** `out_valid = 0`. `out_result` and `out_class` hold the last popped entry, or 0 after reset. A push into an empty FIFO is not visible on the output in the same cycle; there is no bypass path.
- **Counters:** updated on accepted pushes only.
  - `nan_count` increments on class 4; `inf_count` increments on class 3.
  - Both saturate at all-ones.
  - `clear_stats` takes priority over an increment in the same cycle: the counter goes to 0 and that push is not counted.
- **Reset:** `rst_n` sampled low at a rising edge sets `count`, both pointers, `out_result`, `out_class`, `nan_count` and `inf_count` to 0, and makes `out_valid = 0`.
  - No push or pop takes effect in a reset cycle.
  - `in_ready` is 1 from the first edge after reset.
  - Reset asserted mid-stream discards all buffered entries.

## Timing
- **Latency:** 1 cycle. An entry pushed at edge N is presented with `out_valid = 1` after edge N.
- **Throughput:** one push and one pop per cycle, sustained.
- **`in_ready`:** depends only on registered `count`. There is no combinational path from `out_ready` to `in_ready`.
- **`out_valid`:** registered.
- **`out_result` / `out_class`:** read from storage at the read pointer, then registered. Pop at edge N presents the next entry after edge N.
- **Counters:** update at the edge of the accepting push.

## Configuration
- `FPA_RESULT_STATS_EN` defined: the classification-based counters and the `clear_stats` logic are built as described above.
- `FPA_RESULT_STATS_EN` undefined:
  - Counter logic is compiled out.
  - `nan_count` and `inf_count` are tied to 0 and `clear_stats` is ignored.
  - Ports remain, so instantiations are identical in both builds.
  - FIFO and `out_class` behaviour is unchanged.

## Test plan
- **Reset and single push:** hold `rst_n = 0` for 2 cycles, then push `0x3F800000`. Before the push, all outputs are 0. One cycle after the push, `out_valid = 1`, `out_result = 0x3F800000`, `out_class = 0`.
- **Fill and drain:** with `out_ready = 0`, push 5 values.
  - Only 4 are accepted; `in_ready = 0` after the 4th push.
  - Raising `out_ready` drains the 4 in order.
  - Exactly 4 pops occur and `out_valid` then drops.
- **Classification:** push `0x00000000` → class 1, `0x80000001` → class 2, `0xFF800000` → class 3, `0x7FC00000` → class 4, `0x40490FDB` → class 0.
- **Pointer wrap and simultaneous push/pop:** hold `in_valid = out_ready = 1` for 10 cycles with an incrementing mantissa. Outputs appear in order, `count` stays at 1, and no entry is lost across the pointer wrap.
- **Statistics** (with `FPA_RESULT_STATS_EN`):
  - 3 NaN pushes and 2 infinity pushes → `nan_count = 3`, `inf_count = 2`.
  - `clear_stats` asserted in the same cycle as a NaN push → both counters 0.
  - With `CNT_W = 2`, 5 NaN pushes → `nan_count = 3` (saturated).
- **Mid-stream reset:** reset while 3 entries are buffered → next cycle `out_valid = 0`, `in_ready = 1`, all counters 0.

Source files
------------

// File: rtl/fpa_result_fifo.sv
// fpa_result_fifo
//   Registered output stage for the combinational fpa adder. Results are
//   captured through a valid/ready handshake into a DEPTH-entry FIFO. Each
//   entry is tagged with its IEEE-754 single-precision class. The head entry
//   is presented from registers, so the adder's combinational path ends at
//   a flop.
//
//   Optional build macro: FPA_RESULT_STATS_EN
//     defined   -> saturating NaN / infinity counters with clear_stats
//     undefined -> counters compiled out, nan_count/inf_count tied to 0
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   producer handshake (in_ready = count != DEPTH)
//   sign, exp, mantis     result fields from fpa
//   out_valid / out_ready consumer handshake
//   out_result            head entry {sign, exp, mantis}
//   out_class             0 normal, 1 zero, 2 denormal, 3 inf, 4 NaN
//   clear_stats           synchronous clear of both counters
//   nan_count, inf_count  accepted NaN / infinity results (saturating)
module fpa_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign,
    input  logic [7:0]       exp,
    input  logic [22:0]      mantis,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [2:0]       out_class,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] nan_count,
    output logic [CNT_W-1:0] inf_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] CLS_NORM = 3'd0;
    localparam logic [2:0] CLS_ZERO = 3'd1;
    localparam logic [2:0] CLS_DEN  = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_NAN  = 3'd4;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_result_q, out_result_d;
    logic [2:0]    out_class_q, out_class_d;

    // Storage entry: {class, sign, exp, mantis}
    logic [34:0]   mem_q [DEPTH];
    logic [34:0]   in_entry;
    logic [34:0]   head;
    logic [2:0]    in_class;
    logic          push, pop;

    always_comb begin
        in_class = CLS_NORM;
        if (exp == 8'hFF) begin
            in_class = (mantis != '0) ? CLS_NAN : CLS_INF;
        end else if (exp == 8'h00) begin
            in_class = (mantis == '0) ? CLS_ZERO : CLS_DEN;
        end
    end

    assign in_entry = {in_class, sign, exp, mantis};
    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);

        // The entry that becomes head may be the one being written this
        // cycle (push into empty, or push+pop with one entry buffered); take
        // it straight from the input since storage is not yet updated.
        head = mem_q[rd_ptr_d];
        if (push && (wr_ptr_q == rd_ptr_d)) head = in_entry;

        out_valid_d  = (count_d != '0);
        out_result_d = out_result_q;
        out_class_d  = out_class_q;
        // When empty the output registers keep the last popped entry.
        if (count_d != '0) begin
            out_result_d = head[31:0];
            out_class_d  = head[34:32];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_class_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_class_q  <= out_class_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem_q[wr_ptr_q] <= in_entry;
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_class  = out_class_q;

`ifdef FPA_RESULT_STATS_EN
    logic [CNT_W-1:0] nan_count_q, nan_count_d;
    logic [CNT_W-1:0] inf_count_q, inf_count_d;

    always_comb begin
        nan_count_d = nan_count_q;
        inf_count_d = inf_count_q;
        if (clear_stats) begin
            // Clear wins over a same-cycle increment.
            nan_count_d = '0;
            inf_count_d = '0;
        end else if (push) begin
            if (in_class == CLS_NAN && nan_count_q != '1) nan_count_d = nan_count_q + CNT_W'(1);
            if (in_class == CLS_INF && inf_count_q != '1) inf_count_d = inf_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nan_count_q <= '0;
            inf_count_q <= '0;
        end else begin
            nan_count_q <= nan_count_d;
            inf_count_q <= inf_count_d;
        end
    end

    assign nan_count = nan_count_q;
    assign inf_count = inf_count_q;
`else
    logic unused_clear_stats;
    assign unused_clear_stats = clear_stats;
    assign nan_count = '0;
    assign inf_count = '0;
`endif

endmodule

// File: tb/tb_fpa_result_fifo.sv
// Self-checking bench for fpa_result_fifo. A queue scoreboard records each
// accepted push and is popped when the DUT hands over its head entry; every
// cycle the handshake outputs, head entry and counters are checked against
// the scoreboard and a counter model.
module tb_fpa_result_fifo;
    localparam int DEPTH = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             sign = 1'b0;
    logic [7:0]       exp_i = '0;
    logic [22:0]      mantis = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic [2:0]       out_class;
    logic             clear_stats = 1'b0;
    logic [CNT_W-1:0] nan_count;
    logic [CNT_W-1:0] inf_count;

    fpa_result_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sign(sign), .exp(exp_i), .mantis(mantis),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_class(out_class),
        .clear_stats(clear_stats), .nan_count(nan_count), .inf_count(inf_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [34:0] sb[$];
    logic [34:0] last_pop = '0;
    int          exp_nan = 0;
    int          exp_inf = 0;
    int          pops = 0;
    bit          mdl_ok = 1'b0;

    function automatic logic [2:0] cls(logic [31:0] v);
        if (v[30:23] == 8'hFF) return (v[22:0] != 0) ? 3'd4 : 3'd3;
        if (v[30:23] == 8'h00) return (v[22:0] == 0) ? 3'd1 : 3'd2;
        return 3'd0;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_in(logic [31:0] v);
        {sign, exp_i, mantis} = v;
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the
    // model across the rising edge. Inputs are changed by the caller after.
    task automatic cycle();
        bit          do_push, do_pop;
        logic [34:0] e;
        int          sat;
        sat = (1 << CNT_W) - 1;
        @(negedge clk);
        if (mdl_ok) begin
            chk("in_ready", 64'(in_ready), 64'(sb.size() != DEPTH));
            chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
            if (sb.size() != 0) begin
                chk("head_result", 64'(out_result), 64'(sb[0][31:0]));
                chk("head_class", 64'(out_class), 64'(sb[0][34:32]));
            end else begin
                chk("hold_result", 64'(out_result), 64'(last_pop[31:0]));
                chk("hold_class", 64'(out_class), 64'(last_pop[34:32]));
            end
            chk("nan_count", 64'(nan_count), 64'(exp_nan));
            chk("inf_count", 64'(inf_count), 64'(exp_inf));
        end
        do_push = rst_n && in_valid && (sb.size() != DEPTH);
        do_pop  = rst_n && out_ready && (sb.size() != 0);
        e = {cls({sign, exp_i, mantis}), sign, exp_i, mantis};
        @(posedge clk);
        if (!rst_n) begin
            sb.delete();
            last_pop = '0;
            exp_nan = 0;
            exp_inf = 0;
            mdl_ok = 1'b1;
        end else begin
            if (do_pop) begin
                last_pop = sb.pop_front();
                pops++;
            end
            if (do_push) sb.push_back(e);
`ifdef FPA_RESULT_STATS_EN
            if (clear_stats) begin
                exp_nan = 0;
                exp_inf = 0;
            end else if (do_push) begin
                if (e[34:32] == 3'd4 && exp_nan < sat) exp_nan++;
                if (e[34:32] == 3'd3 && exp_inf < sat) exp_inf++;
            end
`endif
        end
        #1;
    endtask

    logic [31:0] cls_vec [5];
    int          p0;

    initial begin
        // Reset for 2 cycles, then a single push.
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        in_valid = 1'b1;
        set_in(32'h3F80_0000);
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("single_push_result", 64'(out_result), 64'h3F80_0000);
        chk("single_push_class", 64'(out_class), 64'd0);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();

        // Fill with 5 offers while the consumer stalls; only 4 fit.
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(32'h4000_0000 + 32'(i));
            cycle();
        end
        chk("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 6; i++) cycle();
        chk("drain_pops", 64'(pops - p0), 64'd4);
        chk("drain_last", 64'(out_result), 64'h4000_0003);
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Classification, consumer always ready.
        cls_vec[0] = 32'h0000_0000;
        cls_vec[1] = 32'h8000_0001;
        cls_vec[2] = 32'hFF80_0000;
        cls_vec[3] = 32'h7FC0_0000;
        cls_vec[4] = 32'h4049_0FDB;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(cls_vec[i]);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("class_normal_last", 64'(out_class), 64'd0);
        cycle();

        // Streaming push+pop across the pointer wrap.
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_in({1'b0, 8'h7F, 23'(i + 1)});
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk("wrap_last", 64'(out_result), 64'({1'b0, 8'h7F, 23'd10}));
        cycle();

        // Statistics.
        clear_stats = 1'b1;
        cycle();
        clear_stats = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(32'h7FC0_0000 | 32'(i));
            cycle();
        end
        set_in(32'h7F80_0000);
        cycle();
        set_in(32'hFF80_0000);
        cycle();
        in_valid = 1'b0;
        cycle();
`ifdef FPA_RESULT_STATS_EN
        chk("stats_nan3", 64'(nan_count), 64'd3);
        chk("stats_inf2", 64'(inf_count), 64'd2);
`else
        chk("stats_nan_off", 64'(nan_count), 64'd0);
        chk("stats_inf_off", 64'(inf_count), 64'd0);
`endif
        in_valid = 1'b1;
        clear_stats = 1'b1;
        set_in(32'h7FC0_0000);
        cycle();
        clear_stats = 1'b0;
        in_valid = 1'b0;
        cycle();
        chk("clear_nan", 64'(nan_count), 64'd0);
        chk("clear_inf", 64'(inf_count), 64'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(32'hFFC0_0000 | 32'(i));
            cycle();
        end
        in_valid = 1'b0;
        cycle();
`ifdef FPA_RESULT_STATS_EN
        chk("nan_saturate", 64'(nan_count), 64'd3);
`endif
        cycle();

        // Mid-stream reset with 3 entries buffered.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(32'h7F80_0000);
            cycle();
        end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        in_valid = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_nan", 64'(nan_count), 64'd0);
        chk("rst_inf", 64'(inf_count), 64'd0);
        chk("rst_result", 64'(out_result), 64'd0);
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
